target_placement_controller: RTL and testbench

- Sequences the pseudo-random coordinate generator to place a new snake target.
- On a placement request: strobes the generator, captures the candidate, range-checks it, then scans the snake body memory for overlap.
- Retries on reject, up to a retry limit, then falls back to a fixed safe position.
- Sits between the game-control FSM, the random generator and the snake segment RAM; drives the target coordinates consumed by the VGA draw logic.

---
 rtl/target_placement_controller.sv | 148 ++++++++++++++
 tb/tb_target_placement_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_placement_controller.sv
// Places a new snake target: draws random candidates, range-checks them, scans the
// snake body for overlap, retries on reject and falls back to a fixed safe spot.
module target_placement_controller #(
    parameter int unsigned MAX_X      = 159,
    parameter int unsigned MAX_Y      = 119,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned MAX_TRIES  = 8,
    parameter int unsigned FALLBACK_X = 80,
    parameter int unsigned FALLBACK_Y = 60
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Place_Req,
    input  logic [ADDR_W:0]   Snake_Length,
    output logic              Rand_Strobe,
    input  logic [7:0]        Rand_X,
    input  logic [6:0]        Rand_Y,
    output logic [ADDR_W-1:0] Seg_Addr,
    input  logic [7:0]        Seg_X,
    input  logic [6:0]        Seg_Y,
    output logic [7:0]        Target_X,
    output logic [6:0]        Target_Y,
    output logic              Target_Valid,
    output logic              Busy,
    output logic              Fallback_Used
);

    localparam logic [7:0]        LP_MAX_X   = 8'(MAX_X);
    localparam logic [6:0]        LP_MAX_Y   = 7'(MAX_Y);
    localparam logic [7:0]        LP_TRIES   = 8'(MAX_TRIES);
    localparam logic [7:0]        LP_FB_X    = 8'(FALLBACK_X);
    localparam logic [6:0]        LP_FB_Y    = 7'(FALLBACK_Y);
    localparam logic [ADDR_W:0]   LP_LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LP_IDX_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_CHECK, S_SCAN_RD, S_SCAN_CMP, S_FALLBACK, S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_tries;
    logic [7:0]        r_cand_x;
    logic [6:0]        r_cand_y;
    logic [7:0]        r_target_x;
    logic [6:0]        r_target_y;
    logic              r_valid;
    logic              r_fallback;
    logic              r_rand_strobe;

    logic              w_range_ok;
    logic              w_hit;
    logic              w_last;
    logic              w_reject;
    logic [7:0]        w_tries_inc;

    assign w_range_ok  = (r_cand_x != 8'd0) && (r_cand_x <= LP_MAX_X) &&
                         (r_cand_y != 7'd0) && (r_cand_y <= LP_MAX_Y);
    assign w_hit       = (Seg_X == r_cand_x) && (Seg_Y == r_cand_y);
    assign w_last      = ({1'b0, r_idx} == (r_len - LP_LEN_ONE));
    assign w_reject    = ((r_state == S_CHECK) && !w_range_ok) ||
                         ((r_state == S_SCAN_CMP) && w_hit);
    assign w_tries_inc = r_tries + 8'd1;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: the default at the top keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (Place_Req) w_next_state = S_REQ;
            S_REQ:      w_next_state = S_WAIT;
            S_WAIT:     w_next_state = S_CHECK;
            S_CHECK:    if (w_range_ok)
                            w_next_state = (r_len == '0) ? S_DONE : S_SCAN_RD;
            S_SCAN_RD:  w_next_state = S_SCAN_CMP;
            S_SCAN_CMP: if (!w_hit && w_last) w_next_state = S_DONE;
                        else if (!w_hit)      w_next_state = S_SCAN_RD;
            S_FALLBACK: w_next_state = S_DONE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
        if (w_reject)
            w_next_state = (w_tries_inc == LP_TRIES) ? S_FALLBACK : S_REQ;
    end

    always_comb begin
        Busy          = (r_state != S_IDLE);
        Rand_Strobe   = r_rand_strobe;
        Seg_Addr      = r_idx;
        Target_X      = r_target_x;
        Target_Y      = r_target_y;
        Target_Valid  = r_valid;
        Fallback_Used = r_fallback;
    end

    // Strobe is registered from the next state so it is high exactly while in REQ.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rand_strobe <= 1'b0;
            r_len         <= '0;
            r_idx         <= '0;
            r_tries       <= 8'd0;
            r_cand_x      <= 8'd0;
            r_cand_y      <= 7'd0;
            r_target_x    <= LP_FB_X;
            r_target_y    <= LP_FB_Y;
            r_valid       <= 1'b0;
            r_fallback    <= 1'b0;
        end else begin
            r_rand_strobe <= (w_next_state == S_REQ);
            case (r_state)
                S_IDLE: if (Place_Req) begin
                    r_len      <= Snake_Length;
                    r_valid    <= 1'b0;
                    r_fallback <= 1'b0;
                    r_tries    <= 8'd0;
                end
                S_WAIT: begin
                    r_cand_x <= Rand_X;
                    r_cand_y <= Rand_Y;
                end
                S_CHECK:    if (w_range_ok) r_idx <= '0;
                S_SCAN_CMP: if (!w_hit && !w_last) r_idx <= r_idx + LP_IDX_ONE;
                S_FALLBACK: begin
                    r_cand_x   <= LP_FB_X;
                    r_cand_y   <= LP_FB_Y;
                    r_fallback <= 1'b1;
                end
                S_DONE: begin
                    r_target_x <= r_cand_x;
                    r_target_y <= r_cand_y;
                    r_valid    <= 1'b1;
                end
                default: ;
            endcase
            if (w_reject) r_tries <= w_tries_inc;
        end
    end

endmodule

// File: tb/tb_target_placement_controller.sv
// Scoreboard bench: a loop-based reference model predicts each placement, a monitor
// compares when Target_Valid rises.
module tb_target_placement_controller;

    localparam int MAX_TRIES = 8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       Place_Req;
    logic [6:0] Snake_Length;
    logic       Rand_Strobe;
    logic [7:0] Rand_X;
    logic [6:0] Rand_Y;
    logic [5:0] Seg_Addr;
    logic [7:0] Seg_X;
    logic [6:0] Seg_Y;
    logic [7:0] Target_X;
    logic [6:0] Target_Y;
    logic       Target_Valid;
    logic       Busy;
    logic       Fallback_Used;

    target_placement_controller dut (
        .CLK(CLK), .RESET(RESET), .Place_Req(Place_Req), .Snake_Length(Snake_Length),
        .Rand_Strobe(Rand_Strobe), .Rand_X(Rand_X), .Rand_Y(Rand_Y),
        .Seg_Addr(Seg_Addr), .Seg_X(Seg_X), .Seg_Y(Seg_Y),
        .Target_X(Target_X), .Target_Y(Target_Y), .Target_Valid(Target_Valid),
        .Busy(Busy), .Fallback_Used(Fallback_Used)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int x; int y; int fb; int lat; int strobes; int req_edge; int strobe_base;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   strobe_cnt = 0;
    int   bx[64];
    int   by[64];
    int   gq_x[$];
    int   gq_y[$];
    exp_t sb[$];
    logic mon_prev = 1'b0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Environment models: segment RAM with one-cycle read, generator fed from a queue.
    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        Seg_X <= 8'(bx[Seg_Addr]);
        Seg_Y <= 7'(by[Seg_Addr]);
        if (Rand_Strobe) strobe_cnt <= strobe_cnt + 1;
        if (Rand_Strobe && gq_x.size() > 0) begin
            Rand_X <= 8'(gq_x.pop_front());
            Rand_Y <= 7'(gq_y.pop_front());
        end else begin
            Rand_X <= 8'($urandom);
            Rand_Y <= 7'($urandom);
        end
    end

    // Reference: walk candidates in order, count edges per step of the algorithm.
    function automatic exp_t ref_model(int len, int cx[$], int cy[$]);
        exp_t e;
        bit   ok;
        e = '{x: 80, y: 60, fb: 1, lat: 0, strobes: 0, req_edge: 0, strobe_base: 0};
        for (int i = 0; i < MAX_TRIES; i++) begin
            e.strobes = i + 1;
            e.lat += 3;
            ok = cx[i] >= 1 && cx[i] <= 159 && cy[i] >= 1 && cy[i] <= 119;
            if (ok) begin
                for (int k = 0; k < len; k++) begin
                    e.lat += 2;
                    if (bx[k] == cx[i] && by[k] == cy[i]) begin
                        ok = 0;
                        break;
                    end
                end
            end
            if (ok) begin
                e.x = cx[i]; e.y = cy[i]; e.fb = 0; e.lat += 1;
                return e;
            end
        end
        e.lat += 2;
        return e;
    endfunction

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RESET && Target_Valid && !mon_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("target_x", int'(Target_X), e.x);
                check("target_y", int'(Target_Y), e.y);
                check("fallback_used", int'(Fallback_Used), e.fb);
                check("latency", cyc - e.req_edge, e.lat);
                check("strobes", strobe_cnt - e.strobe_base, e.strobes);
                check("busy_at_done", int'(Busy), 0);
            end
        end
        mon_prev <= Target_Valid;
    end

    task automatic place(int len, int cx[$], int cy[$], bit dbl_req);
        exp_t e;
        @(negedge CLK);
        gq_x = cx;
        gq_y = cy;
        e = ref_model(len, cx, cy);
        e.req_edge    = cyc + 1;
        e.strobe_base = strobe_cnt;
        sb.push_back(e);
        Snake_Length = 7'(len);
        Place_Req    = 1'b1;
        @(negedge CLK);
        Place_Req    = 1'b0;
        Snake_Length = 7'($urandom_range(0, 64));
        check("busy_after_req", int'(Busy), 1);
        check("valid_cleared", int'(Target_Valid), 0);
        check("fb_cleared", int'(Fallback_Used), 0);
        if (dbl_req) begin
            @(negedge CLK);
            Place_Req = 1'b1;
            @(negedge CLK);
            Place_Req = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check("done_timeout", sb.size(), 0);
        sb.delete();
        repeat (3) @(negedge CLK);
    endtask

    function automatic int rnd_x();
        case ($urandom_range(0, 6))
            0:       return 0;
            1:       return 159;
            2:       return 160;
            3:       return $urandom_range(161, 255);
            default: return $urandom_range(1, 12);
        endcase
    endfunction

    function automatic int rnd_y();
        case ($urandom_range(0, 6))
            0:       return 0;
            1:       return 119;
            2:       return 120;
            3:       return $urandom_range(121, 127);
            default: return $urandom_range(1, 12);
        endcase
    endfunction

    initial begin
        int cx[$];
        int cy[$];
        int addr_seq[6];
        int base;
        int len;
        RESET = 1'b1; Place_Req = 1'b0; Snake_Length = '0;
        #1;
        check("rst_target_x", int'(Target_X), 80);
        check("rst_target_y", int'(Target_Y), 60);
        check("rst_valid", int'(Target_Valid), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_strobe", int'(Rand_Strobe), 0);
        check("rst_seg_addr", int'(Seg_Addr), 0);
        check("rst_fallback", int'(Fallback_Used), 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        // Empty body, first candidate accepted.
        cx = '{40}; cy = '{30};
        place(0, cx, cy, 0);
        wait_done();

        // Three-segment body, no collision; observe the scan addresses.
        bx[0] = 10; by[0] = 10; bx[1] = 11; by[1] = 10; bx[2] = 12; by[2] = 10;
        place(3, cx, cy, 0);
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            addr_seq[i] = int'(Seg_Addr);
            @(negedge CLK);
        end
        for (int i = 0; i < 6; i++) check("seg_addr_seq", addr_seq[i], i / 2);
        wait_done();

        // Two range rejects, then accept.
        cx = '{0, 200, 40}; cy = '{30, 30, 30};
        place(0, cx, cy, 0);
        wait_done();

        // Every candidate collides: fallback after MAX_TRIES strobes.
        cx = {}; cy = {};
        for (int i = 0; i < MAX_TRIES; i++) begin cx.push_back(11); cy.push_back(10); end
        place(3, cx, cy, 0);
        wait_done();

        // Second request while busy is ignored.
        cx = '{40}; cy = '{30};
        place(2, cx, cy, 1);
        wait_done();

        // Reset during SCAN_CMP of segment 0.
        cx = '{50}; cy = '{50};
        place(3, cx, cy, 0);
        repeat (4) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("mid_rst_target_x", int'(Target_X), 80);
        check("mid_rst_target_y", int'(Target_Y), 60);
        check("mid_rst_valid", int'(Target_Valid), 0);
        check("mid_rst_busy", int'(Busy), 0);
        sb.delete();
        @(negedge CLK);
        RESET = 1'b0;
        base = strobe_cnt;
        repeat (10) @(negedge CLK);
        check("no_strobe_after_rst", strobe_cnt - base, 0);
        check("idle_after_rst", int'(Busy), 0);

        // Randomized placements.
        for (int t = 0; t < 40; t++) begin
            len = ($urandom_range(0, 9) == 0) ? 64 : $urandom_range(0, 10);
            for (int k = 0; k < 64; k++) begin
                bx[k] = $urandom_range(1, 12);
                by[k] = $urandom_range(1, 12);
            end
            cx = {}; cy = {};
            for (int i = 0; i < MAX_TRIES; i++) begin
                int j;
                if (len > 0 && $urandom_range(0, 2) == 0) begin
                    j = $urandom_range(0, len - 1);
                    cx.push_back(bx[j]); cy.push_back(by[j]);
                end else begin
                    cx.push_back(rnd_x()); cy.push_back(rnd_y());
                end
            end
            place(len, cx, cy, $urandom_range(0, 3) == 0);
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
